// File: rtl/wide_adder_pkg.sv
// rtl/wide_adder_pkg.sv - shared types and constants for the multi-word sequential adder
package wide_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } wide_add_state_t;

  localparam int DEFAULT_WORDS = 4;

  // Word counter width; kept at least 1 bit so a degenerate count still has a register.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WORDS);

endpackage

// File: rtl/adder_32.sv
// rtl/adder_32.sv - combinational word adder with carry-in and carry-out
module adder_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};

endmodule

// File: rtl/wide_adder_seq.sv
// rtl/wide_adder_seq.sv - word-serial wide adder around one adder_32; WIDE_ADDER_SEQ_OVF_EN adds ovf_o
module wide_adder_seq
  import wide_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [WIDTH*WORDS-1:0] a_i,
  input  logic [WIDTH*WORDS-1:0] b_i,
  input  logic                   carry_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic [WIDTH*WORDS-1:0] sum_o,
  output logic                   carry_o
`ifdef WIDE_ADDER_SEQ_OVF_EN
  ,
  output logic                   ovf_o
`endif
);

  localparam int CW = cnt_width(WORDS);

  wide_add_state_t state, state_next;

  logic [CW-1:0]                cnt;
  logic [WORDS-1:0][WIDTH-1:0]  a_reg;
  logic [WORDS-1:0][WIDTH-1:0]  b_reg;
  logic [WORDS-1:0][WIDTH-1:0]  sum_reg;
  logic                         carry_reg;
  logic [WIDTH-1:0]             add_sum;
  logic                         add_carry;
  logic                         last_word;

  assign last_word = (cnt == CW'(WORDS - 1));

  adder_32 #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i    (a_reg[cnt]),
    .b_i    (b_reg[cnt]),
    .carry_i(carry_reg),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_word) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_o    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are captured once so the caller may change a_i/b_i during the add.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_reg     <= a_i;
            b_reg     <= b_i;
            carry_reg <= carry_i;
            cnt       <= '0;
          end
        end
        ADD: begin
          sum_reg[cnt] <= add_sum;
          carry_reg    <= add_carry;
          if (!last_word) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_o   = sum_reg;
  assign carry_o = carry_reg;

`ifdef WIDE_ADDER_SEQ_OVF_EN
  logic ovf_reg;

  // Signed overflow only depends on the top word, so it is captured with the final word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_reg <= 1'b0;
    end else if (state == ADD && last_word) begin
      ovf_reg <= (a_reg[WORDS-1][WIDTH-1] == b_reg[WORDS-1][WIDTH-1]) &&
                 (add_sum[WIDTH-1] != a_reg[WORDS-1][WIDTH-1]);
    end
  end

  assign ovf_o = ovf_reg;
`endif

endmodule
